// File: rtl/jk_excitation_driver.sv
// Drives a raw JK register bank toward buffered target words, checking readback against a shadow copy.
// Latency: a word pushed into an empty FIFO while idle is excited onto the bank 2 edges after its push edge.
// Backpressure: tgt_ready = !full; a full FIFO refuses a push even when a pop happens on the same edge.

module jk_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [W-1:0]               wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (cnt != CW'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_dat;
    end
endmodule

module jk_excitation_driver #(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TOGGLE_PREF = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              tgt_data,
    input  logic                          tgt_valid,
    output logic                          tgt_ready,
    output logic [WIDTH-1:0]              j,
    output logic [WIDTH-1:0]              k,
    input  logic [WIDTH-1:0]              q_fb,
    output logic [WIDTH-1:0]              shadow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          mismatch,
    output logic [WIDTH-1:0]              mm_bits,
    input  logic                          err_clr
);
    typedef enum logic [1:0] {st_init, st_idle, st_drive, st_check} state_t;

    state_t           state;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] head;
    logic             head_vld;
    logic             pop;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] diff;
    logic             chk_hit;

    jk_fifo #(.W(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tgt_valid),
        .wr_rdy (tgt_ready),
        .wr_dat (tgt_data),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head),
        .cnt    (fifo_cnt)
    );

    assign pop     = ((state == st_idle) || (state == st_check)) && head_vld;
    assign diff    = q_fb ^ shadow;
    assign chk_hit = (state == st_check) && (diff != '0);
    assign busy    = (state != st_idle) || head_vld;

    // Excitation is computed against the head word so j/k are registered in step with DRIVE.
    always_comb begin
        exc_j = '0;
        exc_k = '0;
        if (TOGGLE_PREF != 0) begin
            exc_j = shadow ^ head;
            exc_k = shadow ^ head;
        end else begin
            exc_j = ~shadow & head;
            exc_k = shadow & ~head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_init;
            j        <= '0;
            k        <= '1;
            t        <= '0;
            shadow   <= '0;
            mismatch <= 1'b0;
            mm_bits  <= '0;
        end else begin
            j <= '0;
            k <= '0;
            case (state)
                st_init: begin
                    shadow <= '0;
                    state  <= st_check;
                end
                st_drive: begin
                    shadow <= t;
                    state  <= st_check;
                end
                default: begin
                    if (pop) begin
                        t     <= head;
                        j     <= exc_j;
                        k     <= exc_k;
                        state <= st_drive;
                    end else begin
                        state <= st_idle;
                    end
                end
            endcase

            // A fresh mismatch wins over a simultaneous clear but drops the older bits.
            if (chk_hit) begin
                mismatch <= 1'b1;
                mm_bits  <= (err_clr ? '0 : mm_bits) | diff;
            end else if (err_clr) begin
                mismatch <= 1'b0;
                mm_bits  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset and toggle excitation) against a word-level model.
module tb_jk_excitation_driver;
    localparam int D = 4;
    localparam int P_INIT = 0, P_IDLE = 1, P_DRIVE = 2, P_CHECK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, tgt_valid = 1'b0, err_clr = 1'b0, force_en = 1'b0;
    logic [7:0] tgt_data = 8'h00, corrupt = 8'h00, force_val = 8'h00;
    logic [7:0] j0, k0, j1, k1, sh0, sh1, mmb0, mmb1, bank0, bank1, qfb0, qfb1;
    logic       rdy0, rdy1, busy0, busy1, mm0, mm1;
    logic [2:0] cnt0, cnt1;

    assign qfb0 = force_en ? force_val : (bank0 ^ corrupt);
    assign qfb1 = force_en ? force_val : (bank1 ^ corrupt);

    jk_excitation_driver #(.WIDTH(8), .FIFO_DEPTH(D), .TOGGLE_PREF(0)) dut0 (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
        .j(j0), .k(k0), .q_fb(qfb0), .shadow(sh0), .busy(busy0), .fifo_cnt(cnt0),
        .mismatch(mm0), .mm_bits(mmb0), .err_clr(err_clr));
    jk_excitation_driver #(.WIDTH(8), .FIFO_DEPTH(D), .TOGGLE_PREF(1)) dut1 (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
        .j(j1), .k(k1), .q_fb(qfb1), .shadow(sh1), .busy(busy1), .fifo_cnt(cnt1),
        .mismatch(mm1), .mm_bits(mmb1), .err_clr(err_clr));

    // Physical JK banks with no reset: hold / set / reset / toggle per bit.
    always @(posedge clk) begin
        bank0 <= (j0 & ~bank0) | (~k0 & bank0);
        bank1 <= (j1 & ~bank1) | (~k1 & bank1);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: pending queue, phase, shadow, expected excitation per instance.
    int         m_ph = P_INIT;
    bit         armed = 1'b0, m_after_drive = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] m_sh = 8'h00, m_t = 8'h00;
    logic [7:0] m_j[2], m_k[2], m_mmb[2];
    bit         m_mm[2];

    function automatic void excite(input logic [7:0] s, input logic [7:0] t,
                                   output logic [7:0] ja, output logic [7:0] ka,
                                   output logic [7:0] jb, output logic [7:0] kb);
        ja = 8'h00; ka = 8'h00; jb = 8'h00; kb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case ({s[i], t[i]})
                2'b01:   ja[i] = 1'b1;
                2'b10:   ka[i] = 1'b1;
                default: ;
            endcase
            jb[i] = (s[i] != t[i]);
            kb[i] = (s[i] != t[i]);
        end
    endfunction

    task automatic model_step();
        logic [7:0] qf[2];
        logic [7:0] d;
        bit take, can_pop;
        int ph_old;
        qf[0] = qfb0; qf[1] = qfb1;
        if (rst) begin
            armed = 1'b1; m_ph = P_INIT; mq.delete(); m_sh = 8'h00; m_after_drive = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_j[i] = 8'h00; m_k[i] = 8'hFF; m_mm[i] = 1'b0; m_mmb[i] = 8'h00;
            end
            return;
        end
        take    = tgt_valid && (mq.size() < D);
        can_pop = ((m_ph == P_IDLE) || (m_ph == P_CHECK)) && (mq.size() > 0);
        for (int i = 0; i < 2; i++) begin
            d = qf[i] ^ m_sh;
            if (m_ph == P_CHECK && d != 8'h00) begin
                m_mm[i] = 1'b1;
                m_mmb[i] = (err_clr ? 8'h00 : m_mmb[i]) | d;
            end else if (err_clr) begin
                m_mm[i] = 1'b0;
                m_mmb[i] = 8'h00;
            end
            m_j[i] = 8'h00; m_k[i] = 8'h00;
        end
        ph_old = m_ph;
        if (m_ph == P_INIT) begin
            m_ph = P_CHECK;
        end else if (m_ph == P_DRIVE) begin
            m_sh = m_t;
            m_ph = P_CHECK;
        end else if (can_pop) begin
            m_t = mq.pop_front();
            excite(m_sh, m_t, m_j[0], m_k[0], m_j[1], m_k[1]);
            m_ph = P_DRIVE;
        end else begin
            m_ph = P_IDLE;
        end
        m_after_drive = (ph_old == P_DRIVE);
        if (take) mq.push_back(tgt_data);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    logic [7:0] dj0[$], dk0[$], dj1[$], dk1[$], slog[$], sent[$];
    bit saw_full = 1'b0;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("ready0", rdy0, mq.size() < D);
            chk("ready1", rdy1, mq.size() < D);
            chk("cnt0", cnt0, mq.size());
            chk("cnt1", cnt1, mq.size());
            chk("busy0", busy0, (m_ph != P_IDLE) || (mq.size() != 0));
            chk("busy1", busy1, (m_ph != P_IDLE) || (mq.size() != 0));
            chk("j0", j0, m_j[0]);
            chk("k0", k0, m_k[0]);
            chk("j1", j1, m_j[1]);
            chk("k1", k1, m_k[1]);
            chk("shadow0", sh0, m_sh);
            chk("shadow1", sh1, m_sh);
            chk("mismatch0", mm0, m_mm[0]);
            chk("mismatch1", mm1, m_mm[1]);
            chk("mm_bits0", mmb0, m_mmb[0]);
            chk("mm_bits1", mmb1, m_mmb[1]);
            if (m_ph == P_DRIVE) begin
                dj0.push_back(j0); dk0.push_back(k0); dj1.push_back(j1); dk1.push_back(k1);
            end
            if (m_ph == P_CHECK && m_after_drive) slog.push_back(sh0);
            if (cnt0 == 3'd4 && !rdy0) saw_full = 1'b1;
        end
    end

    task automatic push_word(input logic [7:0] d);
        bit r, ok;
        ok = 1'b0;
        tgt_data = d;
        tgt_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            r = rdy0;
            @(posedge clk); #2;
            if (r) begin ok = 1'b1; break; end
        end
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (!busy0) begin ok = 1'b1; break; end
        end
        chk("idle_reached", ok, 1);
    endtask

    task automatic clear_logs();
        dj0.delete(); dk0.delete(); dj1.delete(); dk1.delete(); slog.delete();
    endtask

    initial begin
        bit hit;
        logic [7:0] d;

        // Reset: bank forced to zero through one INIT excitation, then idle.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_j", j0, 8'h00);
        chk("rst_k", k0, 8'hFF);
        chk("rst_busy", busy0, 1);
        chk("rst_cnt", cnt0, 0);
        chk("rst_ready", rdy0, 1);
        wait_idle();
        chk("init_shadow", sh0, 8'h00);
        chk("init_mismatch", mm0, 0);
        chk("init_bank", bank0, 8'h00);

        // Two words, both excitation styles.
        clear_logs();
        push_word(8'hA5);
        push_word(8'h0F);
        tgt_valid = 1'b0;
        wait_idle();
        chk("two_drives", dj0.size(), 2);
        if (dj0.size() == 2 && dj1.size() == 2) begin
            chk("drv1_j_sr", dj0[0], 8'hA5); chk("drv1_k_sr", dk0[0], 8'h00);
            chk("drv2_j_sr", dj0[1], 8'h0A); chk("drv2_k_sr", dk0[1], 8'hA0);
            chk("drv1_j_tg", dj1[0], 8'hA5); chk("drv1_k_tg", dk1[0], 8'hA5);
            chk("drv2_j_tg", dj1[1], 8'hAA); chk("drv2_k_tg", dk1[1], 8'hAA);
        end
        chk("end_shadow", sh0, 8'h0F);
        chk("end_bank_sr", bank0, 8'h0F);
        chk("end_bank_tg", bank1, 8'h0F);

        // Eight words with valid held: backpressure, order, no loss or duplication.
        clear_logs();
        sent.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            sent.push_back(d);
            push_word(d);
        end
        tgt_valid = 1'b0;
        wait_idle();
        chk("stream_count", slog.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < slog.size()) chk("stream_order", slog[i], sent[i]);
        chk("stream_full_seen", saw_full, 1);

        // Reset while in DRIVE with three words queued.
        hit = 1'b0;
        tgt_valid = 1'b1;
        tgt_data = 8'($urandom);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #2;
            if (m_ph == P_DRIVE && cnt0 == 3'd3) begin hit = 1'b1; break; end
            tgt_data = 8'($urandom);
        end
        chk("drive_with_3_queued", hit, 1);
        tgt_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        clear_logs();
        chk("midrst_j", j0, 8'h00);
        chk("midrst_k", k0, 8'hFF);
        chk("midrst_cnt", cnt0, 0);
        chk("midrst_shadow", sh0, 8'h00);
        wait_idle();
        chk("midrst_no_drive", dj0.size(), 0);

        // Forced readback error, then clear.
        force_val = 8'h00;
        force_en = 1'b1;
        push_word(8'h01);
        tgt_valid = 1'b0;
        wait_idle();
        force_en = 1'b0;
        chk("mm_set0", mm0, 1);
        chk("mm_bits_set0", mmb0, 8'h01);
        chk("mm_set1", mm1, 1);
        chk("mm_bits_set1", mmb1, 8'h01);
        err_clr = 1'b1;
        @(posedge clk); #2;
        err_clr = 1'b0;
        chk("mm_clr", mm0, 0);
        chk("mm_bits_clr", mmb0, 8'h00);

        // Random traffic with readback corruption, clears and occasional resets.
        for (int c = 0; c < 400; c++) begin
            tgt_valid = ($urandom_range(2) != 0);
            tgt_data  = 8'($urandom);
            err_clr   = ($urandom_range(11) == 0);
            corrupt   = ($urandom_range(5) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
            rst       = ($urandom_range(199) == 0);
            @(posedge clk); #2;
        end
        tgt_valid = 1'b0; err_clr = 1'b0; corrupt = 8'h00; rst = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
